irrigation_sched: RTL
=====================

Name: irrigation_sched

Overview:
Scheduler/controller for the irrigation countdown timer. It arbitrates two irrigation zones round-robin and loads a mode-dependent MM:SS preset. It then counts the preset down in BCD on an external 1 Hz tick, driving the zone valve while running. It pauses on water shortage and reports completion. It sits between the sensor/request logic and the 7-segment display and valve drivers.

Parameters:
SPRK_MT, 4'd1, sprinkler preset tens-of-minutes (BCD)
SPRK_MU, 4'd4, sprinkler preset units-of-minutes (BCD)
DRIP_MT, 4'd3, drip preset tens-of-minutes (BCD)
DRIP_MU, 4'd9, drip preset units-of-minutes (BCD)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-clk strobe at 1 Hz, synchronous to clk
req  input  2  per-zone irrigation request, level
mode  input  2  per-zone mode: 0 sprinkler, 1 drip
water_ok  input  1  1 = tank level sufficient
abort  input  1  synchronous cancel of the current cycle
valve  output  2  one-hot valve enable, registered
active_zone  output  1  zone currently granted
busy  output  1  high in LOAD, RUN, PAUSE
paused  output  1  high in PAUSE
done  output  1  one-clk pulse on normal completion
done_zone  output  1  zone that completed; valid with done, held until next done
Dmin, Umin, Dseg, Useg  output  4 each  BCD remaining time

Behaviour:
- Reset (async, active-high): state IDLE, all outputs 0, digits 00:00, last-served pointer = 1 (zone 0 wins the first tie).
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE: if water_ok=1 and any req bit is set, grant and go to LOAD.
  - One requester: grant it.
  - Both: grant the zone not equal to the last-served pointer.
  - Update the pointer to the granted zone.
- LOAD (1 clk): sample mode[grant]. Load digits {MT,MU,5,9} from the SPRK_* or DRIP_* parameters. active_zone = grant. Tick ignored. Go to RUN.
- RUN:
  - valve = one-hot(active_zone).
  - On tick with digits != 00:00: BCD decrement, Useg first.
  - Borrow chain: Useg 0→9 borrows from Dseg; Dseg 0→5 borrows from Umin; Umin 0→9 borrows from Dmin.
  - On tick with digits == 00:00: go to DONE. Run length = preset + 1 ticks (14:59 → 900 ticks).
- PAUSE: entered from RUN when water_ok=0. Valve 0, digits frozen, ticks ignored. Returns to RUN the first clk water_ok=1.
- DONE (1 clk): done=1, done_zone=active_zone, valve 0. Then IDLE.
- Priority in RUN: abort > water_ok low > tick.
  - water_ok dropping on the final tick → PAUSE, no completion.
- abort in LOAD/RUN/PAUSE: IDLE next clk, valve 0, digits cleared to 00:00, no done pulse. abort in IDLE/DONE has no effect.
- req deassertion after grant is ignored; the cycle runs to completion. mode changes after LOAD are ignored.
- valve changes one clk after the state change (registered). Never more than one bit set.
- A zone still requesting after DONE may be re-granted from IDLE. A pending other zone wins by round-robin.
- Reset mid-operation: immediate return to reset values, valve closes asynchronously.

Test Plan:
1. Reset; req=01, mode=00, water_ok=1, tick every clk. Expect LOAD → digits 14:59, valve=01. Expect done pulse with done_zone=0 exactly 900 ticks after RUN entry; valve 00 in DONE.
2. req=10, mode=10 (zone1 drip). Expect load 39:59, valve=10, done after 2400 ticks. Also check borrow 10:00 → 09:59 and 00:10 → 00:09.
3. req=11 held continuously. Expect grants alternate 0,1,0 across three cycles; done_zone sequence 0,1,0.
4. Drop water_ok at digits 12:30 for 50 ticks. Expect paused=1, valve=00, digits hold 12:30. On restore: RUN, valve=01, next tick → 12:29.
5. abort at 07:15 in RUN. Expect IDLE next clk, digits 00:00, valve 00, no done. Abort while paused gives the same result.
6. Assert reset mid-RUN and release. Expect all outputs 0 immediately. With req=11 afterwards, zone 0 is granted first.

Source files
------------

// File: rtl/irrigation_sched_if.sv
// Request/sensor inputs and valve/display outputs of the irrigation scheduler.
interface irrigation_sched_if;
  logic       tick;
  logic [1:0] req;
  logic [1:0] mode;
  logic       water_ok;
  logic       abort;
  logic [1:0] valve;
  logic       active_zone;
  logic       busy;
  logic       paused;
  logic       done;
  logic       done_zone;
  logic [3:0] Dmin;
  logic [3:0] Umin;
  logic [3:0] Dseg;
  logic [3:0] Useg;

  modport master (
    output tick, req, mode, water_ok, abort,
    input  valve, active_zone, busy, paused, done, done_zone, Dmin, Umin, Dseg, Useg
  );

  modport slave (
    input  tick, req, mode, water_ok, abort,
    output valve, active_zone, busy, paused, done, done_zone, Dmin, Umin, Dseg, Useg
  );
endinterface

// File: rtl/irrigation_sched.sv
// Two-zone round-robin irrigation scheduler with an MM:SS BCD countdown on a 1 Hz tick.
module irrigation_sched #(
  parameter logic [3:0] SPRK_MT = 4'd1,
  parameter logic [3:0] SPRK_MU = 4'd4,
  parameter logic [3:0] DRIP_MT = 4'd3,
  parameter logic [3:0] DRIP_MU = 4'd9
) (
  input logic               clk,
  input logic               reset,
  irrigation_sched_if.slave bus
);

  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic          last_ptr;
  logic          zone;
  logic [DW-1:0] digits;
  logic [1:0]    valve;
  logic          busy;
  logic          paused;
  logic          done;
  logic          done_zone;
  logic          grant_c;
  logic          cancel_c;

  // Single requester wins outright; on a tie the zone not served last wins.
  always_comb begin
    grant_c = 1'b0;
    unique case (bus.req)
      2'b01:   grant_c = 1'b0;
      2'b10:   grant_c = 1'b1;
      default: grant_c = ~last_ptr;
    endcase
  end

  assign cancel_c = bus.abort && (state == LOAD || state == RUN || state == PAUSE);

  // One-second BCD decrement; only called when the time is non-zero.
  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) su = su - 4'd1;
    else begin
      su = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mu != 4'd0) mu = mu - 4'd1;
        else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_ptr  <= 1'b1;
      zone      <= 1'b0;
      digits    <= '0;
      valve     <= 2'b00;
      busy      <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
      done_zone <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel_c) begin
        state  <= IDLE;
        digits <= '0;
        valve  <= 2'b00;
        busy   <= 1'b0;
        paused <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.water_ok && (bus.req != 2'b00)) begin
              state    <= LOAD;
              last_ptr <= grant_c;
              zone     <= grant_c;
              busy     <= 1'b1;
            end
          end
          LOAD: begin
            state  <= RUN;
            digits <= bus.mode[zone] ? {DRIP_MT, DRIP_MU, 4'd5, 4'd9}
                                     : {SPRK_MT, SPRK_MU, 4'd5, 4'd9};
            valve  <= zone ? 2'b10 : 2'b01;
          end
          RUN: begin
            // Water shortage outranks the tick, including the final one.
            if (!bus.water_ok) begin
              state  <= PAUSE;
              paused <= 1'b1;
              valve  <= 2'b00;
            end else if (bus.tick) begin
              if (digits == '0) begin
                state     <= DONE;
                valve     <= 2'b00;
                busy      <= 1'b0;
                done      <= 1'b1;
                done_zone <= zone;
              end else begin
                digits <= bcd_dec(digits);
              end
            end
          end
          PAUSE: begin
            if (bus.water_ok) begin
              state  <= RUN;
              paused <= 1'b0;
              valve  <= zone ? 2'b10 : 2'b01;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.valve       = valve;
  assign bus.active_zone = zone;
  assign bus.busy        = busy;
  assign bus.paused      = paused;
  assign bus.done        = done;
  assign bus.done_zone   = done_zone;
  assign {bus.Dmin, bus.Umin, bus.Dseg, bus.Useg} = digits;

endmodule
